// File: rtl/mt_pkg.sv
// Shared constants, FSM state type and word-level helpers for the MT19937 stream generator.
package mt_pkg;

    localparam int unsigned MT_N  = 624;
    localparam int unsigned MT_M  = 397;
    localparam int unsigned IDX_W = 10;

    localparam logic [31:0] MATRIX_A   = 32'h9908B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h80000000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFFFFFF;
    localparam logic [31:0] INIT_MULT  = 32'd1812433253;

    localparam int unsigned TEMPER_U = 11;
    localparam int unsigned TEMPER_S = 7;
    localparam logic [31:0] TEMPER_B = 32'h9D2C5680;
    localparam int unsigned TEMPER_T = 15;
    localparam logic [31:0] TEMPER_C = 32'hEFC60000;
    localparam int unsigned TEMPER_L = 18;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_TWIST,
        ST_GEN
    } mt_state_e;

    function automatic logic [31:0] mt_temper(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y >> TEMPER_U);
        y = y ^ ((y << TEMPER_S) & TEMPER_B);
        y = y ^ ((y << TEMPER_T) & TEMPER_C);
        y = y ^ (y >> TEMPER_L);
        return y;
    endfunction

    function automatic logic [31:0] mt_twist(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [31:0] far);
        logic [31:0] y;
        y = (cur & UPPER_MASK) | (nxt & LOWER_MASK);
        return far ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'h0);
    endfunction

    function automatic logic [31:0] mt_init_step(input logic [31:0] prev,
                                                 input logic [IDX_W-1:0] idx);
        return INIT_MULT * (prev ^ (prev >> 30)) + 32'(idx);
    endfunction

endpackage

// File: rtl/mt_fifo.sv
// Synchronous output FIFO with flush; accepts a push while full when a pop happens the same cycle.
module mt_fifo
    import mt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mt_stream.sv
// MT19937 generator: seeds and twists a 624-word state one word per cycle, then streams tempered words.
module mt_stream
    import mt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'd5489
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [31:0] seed_value,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MT_N - 1);
    localparam logic [IDX_W-1:0] WRAP_IDX = IDX_W'(MT_N - MT_M);

    mt_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      seed_q, seed_d;
    logic [31:0]      prev_q, prev_d;

    logic [31:0]      mt_q [MT_N];
    logic             mt_we;
    logic [31:0]      mt_wdata;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] idx_far;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;

    // Twist reads the live array, so index 623 sees the new state[0] and
    // indices >= 227 see already-updated words, as the reference does.
    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    assign idx_far  = (idx_q >= WRAP_IDX) ? idx_q - WRAP_IDX : idx_q + IDX_W'(MT_M);

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign busy      = (state_q != ST_GEN);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seed_d     = seed_q;
        prev_d     = prev_q;
        mt_we      = 1'b0;
        mt_wdata   = '0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (seed_load) begin
            fifo_flush = 1'b1;
            seed_d     = seed_value;
            state_d    = ST_SEED;
            idx_d      = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    mt_we    = 1'b1;
                    mt_wdata = (idx_q == '0) ? seed_q : mt_init_step(prev_q, idx_q);
                    prev_d   = mt_wdata;
                    idx_d    = idx_next;
                    if (idx_q == LAST_IDX) state_d = ST_TWIST;
                end
                ST_TWIST: begin
                    mt_we    = 1'b1;
                    mt_wdata = mt_twist(mt_q[idx_q], mt_q[idx_next], mt_q[idx_far]);
                    idx_d    = idx_next;
                    if (idx_q == LAST_IDX) state_d = ST_GEN;
                end
                ST_GEN: begin
                    if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                        idx_d     = idx_next;
                        if (idx_q == LAST_IDX) state_d = ST_TWIST;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_SEED;
            idx_q   <= '0;
            seed_q  <= DEFAULT_SEED;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seed_q  <= seed_d;
            prev_q  <= prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mt_we) mt_q[idx_q] <= mt_wdata;
    end

    mt_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (mt_temper(mt_q[idx_q])),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mt_stream.sv
// Directed/randomised bench for mt_stream against a software MT19937 model.
module tb_mt_stream;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [31:0] seed_value;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    mt_stream #(
        .FIFO_DEPTH   (DEPTH),
        .DEFAULT_SEED (32'd5489)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mt [624];
    int          ref_mti;
    int unsigned words_seen;
    bit          const_seq;
    bit          pv;
    bit          pr;
    logic [31:0] pd;

    function automatic void ref_seed(input logic [31:0] s);
        ref_mt[0] = s;
        for (int i = 1; i < 624; i++)
            ref_mt[i] = 32'd1812433253 * (ref_mt[i-1] ^ (ref_mt[i-1] >> 30)) + 32'(i);
        ref_mti = 624;
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] f);
        logic [31:0] y;
        y = (a & 32'h80000000) | (b & 32'h7fffffff);
        return f ^ (y >> 1) ^ (y[0] ? 32'h9908b0df : 32'h0);
    endfunction

    function automatic logic [31:0] ref_next();
        logic [31:0] y;
        if (ref_mti >= 624) begin
            for (int kk = 0; kk < 227; kk++)
                ref_mt[kk] = ref_mix(ref_mt[kk], ref_mt[kk+1], ref_mt[kk+397]);
            for (int kk = 227; kk < 623; kk++)
                ref_mt[kk] = ref_mix(ref_mt[kk], ref_mt[kk+1], ref_mt[kk-227]);
            ref_mt[623] = ref_mix(ref_mt[623], ref_mt[0], ref_mt[396]);
            ref_mti = 0;
        end
        y = ref_mt[ref_mti];
        ref_mti++;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9d2c5680);
        y = y ^ ((y << 15) & 32'hefc60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        logic [31:0] exp;
        exp = ref_next();
        words_seen++;
        chk("word", out_data, exp);
        if (const_seq && words_seen == 1)     chk("word1_const", out_data, 32'd3499211612);
        if (const_seq && words_seen == 2)     chk("word2_const", out_data, 32'd581869302);
        if (const_seq && words_seen == 10000) chk("word10000_const", out_data, 32'd4123659995);
    endtask

    // One clock: check hold-while-stalled, drive inputs, score a transfer, advance.
    task automatic cyc(input bit rdy, input bit load, input logic [31:0] s);
        if (pv && !pr) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, pd);
        end
        out_ready  = rdy;
        seed_load  = load;
        seed_value = s;
        if (out_valid && rdy) consume();
        pv = out_valid;
        pr = rdy;
        pd = out_data;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic run_words(input int unsigned n, input bit rand_ready, input int unsigned budget);
        int unsigned start;
        int unsigned cycles;
        start  = words_seen;
        cycles = 0;
        while (words_seen - start < n) begin
            if (cycles >= budget) begin
                checks++;
                failures++;
                $error("FAIL timeout_words observed=%0d expected=%0d", words_seen - start, n);
                return;
            end
            cyc(rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1, 1'b0, '0);
            cycles++;
        end
    endtask

    task automatic reseed(input logic [31:0] s, input bit rdy);
        cyc(rdy, 1'b1, s);
        ref_seed(s);
        words_seen = 0;
        const_seq  = (s == 32'd5489);
        pv         = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("seed_busy", busy, 1'b1);
    endtask

    initial begin
        int unsigned n;

        rst        = 1'b0;
        seed_load  = 1'b1;
        seed_value = 32'hFEEDBEEF;
        out_ready  = 1'b1;
        pv         = 1'b0;
        pr         = 1'b0;
        pd         = '0;
        words_seen = 0;
        tick();
        tick();
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_busy", busy, 1'b1);

        // Default seed after reset; seed_load during reset must have no effect.
        seed_load = 1'b0;
        rst       = 1'b1;
        ref_seed(32'd5489);
        const_seq = 1'b1;
        n = 0;
        while (!out_valid && n < 1300) begin
            cyc(1'b1, 1'b0, '0);
            n++;
            if (n == 100) chk("busy_in_seed", busy, 1'b1);
        end
        chk("first_valid_seen", out_valid, 1'b1);
        chk("first_latency_ok", 32'(n <= 1260), 32'd1);
        chk("gen_not_busy", busy, 1'b0);
        run_words(10000, 1'b0, 25000);

        // Random backpressure with a fresh seed.
        reseed(32'hFEEDBEEF, 1'b1);
        run_words(3000, 1'b1, 20000);

        // Long stall: FIFO fills to exactly DEPTH, head is word 1.
        reseed(32'd5489, 1'b0);
        for (int i = 0; i < 2000; i++) cyc(1'b0, 1'b0, '0);
        chk("stall_count", 32'(dut.u_fifo.count_q), DEPTH);
        chk("stall_head_valid", out_valid, 1'b1);
        chk("stall_head_word", out_data, 32'd3499211612);
        run_words(20, 1'b0, 2000);

        // Reseed in the middle of GEN.
        run_words(300, 1'b0, 3000);
        reseed(32'd5489, 1'b1);
        run_words(10, 1'b0, 3000);

        // Reset pulse during TWIST.
        n = 0;
        while (busy && n < 3000) begin cyc(1'b1, 1'b0, '0); n++; end
        while (!busy && n < 4000) begin cyc(1'b1, 1'b0, '0); n++; end
        chk("reached_twist", busy, 1'b1);
        rst       = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 32'h0);
        chk("mid_rst_busy", busy, 1'b1);
        rst = 1'b1;
        ref_seed(32'd5489);
        words_seen = 0;
        const_seq  = 1'b1;
        pv         = 1'b0;
        run_words(5, 1'b0, 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
